// File: rtl/fifo_syn_param.sv
// rtl/fifo_syn_param.sv - parametrised single-clock FIFO with level flags, show-ahead and sticky errors
module fifo_syn_param #(
  parameter int WIDTH      = 8,
  parameter int ADDR_W     = 4,
  parameter int AF_LEVEL   = 12,
  parameter int AE_LEVEL   = 2,
  parameter int SHOW_AHEAD = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr,
  input  logic [WIDTH-1:0]  data,
  input  logic              rd,
  output logic [WIDTH-1:0]  q,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   usedw,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_V    = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_V    = (ADDR_W+1)'(AE_LEVEL);
  localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W:0]   rd_ptr;
  logic              wr_acc;
  logic              rd_acc;

  // The extra pointer bit distinguishes full from empty, so all DEPTH entries are usable.
  assign usedw        = wr_ptr - rd_ptr;
  assign full         = (usedw == DEPTH_V);
  assign empty        = (usedw == '0);
  assign almost_full  = (usedw >= AF_V);
  assign almost_empty = (usedw <= AE_V);

  // A write into a full FIFO is allowed when a read frees the head in the same cycle.
  assign wr_acc = wr & (~full | rd);
  assign rd_acc = rd & ~empty;

  // Storage array; deliberately not reset, writes suppressed while clearing.
  always_ff @(posedge clk) begin
    if (wr_acc && !clr && !rst)
      mem[wr_ptr[ADDR_W-1:0]] <= data;
  end

  // Pointer and sticky error state; clr wins over any request in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ONE;
      if (rd_acc) rd_ptr <= rd_ptr + ONE;
      if (wr && !wr_acc) overflow  <= 1'b1;
      if (rd && !rd_acc) underflow <= 1'b1;
    end
  end

  generate
    if (SHOW_AHEAD != 0) begin : g_show_ahead
      // Head word is presented directly; zero while nothing is stored.
      always_comb begin
        q = '0;
        if (!empty) q = mem[rd_ptr[ADDR_W-1:0]];
      end
    end else begin : g_registered
      logic [WIDTH-1:0] q_reg;
      // Registered read; the nonblocking read returns the old word on an aliased full-FIFO write.
      always_ff @(posedge clk or posedge rst) begin
        if (rst)         q_reg <= '0;
        else if (clr)    q_reg <= '0;
        else if (rd_acc) q_reg <= mem[rd_ptr[ADDR_W-1:0]];
      end
      assign q = q_reg;
    end
  endgenerate

endmodule
